v_lsu_seq: RTL and testbench
============================

Name: v_lsu_seq

Overview:
Sequencer that runs unit-stride vector loads and stores between the vector register file (VRF) and the 4-bank vector data memory. Banks interleave by element: element i sits at row base+i/4 in bank i%4. One row, four 32-bit words, is issued per cycle. The sequencer accounts for the memory's 1-cycle synchronous read latency and generates per-bank byte write enables from vl and the element mask. It sits between the vector coprocessor issue logic and the datamem core-side port (data_addr/dm_write_*/data_in_*/data_out_*).

Parameters:
VLMAX, 32, maximum elements per vector; must be a multiple of 4.
ADDR_BITS, 14, datamem row-address width; MSB selects the protocol region.
GRP_BITS, $clog2(VLMAX/4), VRF element-group index width.

Ports:
core_clk  in  1  gated core clock; all logic on rising edge
nrst  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_store  in  1  1=store, 0=load
req_base  in  ADDR_BITS  base row address
req_vl  in  $clog2(VLMAX)+1  element count
req_vm  in  1  1=unmasked; 0=apply req_mask
req_mask  in  VLMAX  per-element enable, sampled at accept
done  out  1  1-cycle completion pulse
err  out  1  1-cycle rejection pulse
dm_addr  out  ADDR_BITS  to datamem data_addr
dm_write_0..3  out  4 each  bank byte write enables
dm_wdata_0..3  out  32 each  bank write data
dm_rdata_0..3  in  32 each  bank read data, valid 1 cycle after address
vrf_rd_grp  out  GRP_BITS  store group index; combinational read
vrf_rd_data  in  128  store data; word k (bits 32k+31:32k) -> bank k
vrf_wr_en  out  1  load group write strobe
vrf_wr_grp  out  GRP_BITS  load group index
vrf_wr_data  out  128  word k from bank k
vrf_wr_be  out  4  per-word write enable

Behaviour:
- States: IDLE, ISSUE, DRAIN.
- Accept: req_valid && req_ready. At accept, latch base, vl, store, mask. Effective mask = req_vm ? all ones : req_mask, ANDed with (i < vl).
- rows = ceil(vl/4).
- Error at accept: vl > VLMAX, or store with req_base[MSB]=1, or (req_base + rows - 1) differs from req_base in the MSB, or overflows ADDR_BITS. Response: err pulses the next cycle, state stays IDLE, no memory or VRF activity.
- vl=0: IDLE -> DRAIN -> IDLE. done pulses in the DRAIN cycle. No accesses.
- ISSUE: row counter r runs 0..rows-1, one row per cycle. dm_addr = base + r; vrf_rd_grp = r.
  - Store: dm_write_k = 4'hF when the element mask bit for 4r+k is set, else 4'h0; dm_wdata_k = vrf_rd_data word k.
  - Load: dm_write_* = 0.
  - After r = rows-1, go to DRAIN.
- Load return: a registered valid/group/mask pipe, 1 stage. In the cycle after a row issues: vrf_wr_en=1, vrf_wr_grp=r, vrf_wr_data = {dm_rdata_3, dm_rdata_2, dm_rdata_1, dm_rdata_0}, vrf_wr_be = mask bits of row r. A row with all-zero mask still issues and writes with be=0.
- DRAIN: lasts one cycle. A load's final VRF write lands here. done pulses here for both loads and stores, then the state returns to IDLE.
- Latency for a load of N rows: accept at cycle 0, issue at cycles 1..N, VRF writes at cycles 2..N+1, done at cycle N+1. A new accept is possible at cycle N+2.
- Protocol-region loads (base MSB=1) are legal. All banks return the same word; it is passed through unchanged.
- Data is passed through bit-exact; endianness is handled in datamem.
- Outputs outside ISSUE/load-return: dm_addr=0, dm_write_*=0, dm_wdata_*=0, vrf_wr_en=0, vrf_wr_be=0, vrf_wr_data=0, vrf_rd_grp=0.
- Reset values: every output 0 except req_ready. req_ready=0 while nrst=0 and 1 in the first cycle after release.
- Reset mid-operation: abort immediately. The pending load pipe is cleared, so no VRF write and no done occur. Memory writes already clocked remain.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package/include, alongside constants.vh: state encodings (LSU_IDLE/LSU_ISSUE/LSU_DRAIN), VLMAX, the bank count 4, and the DATAMEM_BITS-derived ADDR_BITS.
- Sub-module v_lsu_mask_gen: combinational; (vl, vm, mask, row) -> 4-bit row enable. Shared by the store path and the load return path.

Test Plan:
- Load, base=0x010, vl=8, vm=1, memory preloaded -> VRF writes at cycles 2 and 3: grp0 = rows 0x010 banks 3..0, grp1 = row 0x011; be=4'hF; done at cycle 3.
- Store, base=0x020, vl=6, vm=1 -> row 0x020 dm_write all 4'hF; row 0x021 banks 0,1 = 4'hF, banks 2,3 = 4'h0; readback confirms banks 2,3 of 0x021 unchanged.
- Masked load, vl=4, vm=0, mask=...0101 -> vrf_wr_be=4'b0101, single VRF write, done at cycle 2.
- Errors: vl=33 -> err at cycle 1, no access; store base=0x2000 -> err; load base=0x1FFF, vl=8 (crosses MSB) -> err; vl=0 -> done at cycle 1, no access.
- Reset: nrst low in ISSUE of a 4-row load -> no further vrf_wr_en, no done; the next request after reset completes normally.
- Back-to-back: a second request held valid during a busy load is accepted only in the cycle after done; both complete with correct data.

Source files
------------

// File: rtl/v_lsu_seq_pkg.sv
// Shared constants and state encoding for the unit-stride vector LSU.
// Exports: DATAMEM_BITS, LSU_ADDR_BITS, LSU_VLMAX, LSU_BANKS, lsu_state_t, lsu_rows().
package v_lsu_seq_pkg;

  // Datamem row-address width; the MSB selects the protocol region.
  localparam int DATAMEM_BITS  = 14;
  localparam int LSU_ADDR_BITS = DATAMEM_BITS;

  // Elements per vector (multiple of the bank count).
  localparam int LSU_VLMAX = 32;

  // Element-interleaved datamem banks, one 32-bit word each per row.
  localparam int LSU_BANKS = 4;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_DRAIN = 2'd2
  } lsu_state_t;

  // Rows touched by an access of vl elements: ceil(vl/4).
  // The result is one bit narrower than vl.
  function automatic logic [6:0] lsu_rows(
    input logic [7:0] vl
  );
    logic [8:0] v3;
    v3 = {1'b0, vl} + 9'd3;
    return v3[8:2];
  endfunction

endpackage

// File: rtl/v_lsu_mask_gen.sv
// Per-row element enable: bit k is set when element 4*row+k is below vl
// and is unmasked. Ports: i_vl, i_vm, i_mask, i_row in; o_en out.
module v_lsu_mask_gen
  import v_lsu_seq_pkg::*;
#(
  parameter int VLMAX    = LSU_VLMAX,
  parameter int GRP_BITS = $clog2(VLMAX / 4),
  parameter int VL_BITS  = $clog2(VLMAX) + 1
) (
  input  logic [VL_BITS-1:0]   i_vl,
  input  logic                 i_vm,
  input  logic [VLMAX-1:0]     i_mask,
  input  logic [GRP_BITS-1:0]  i_row,
  output logic [LSU_BANKS-1:0] o_en
);

  for (genvar k = 0; k < LSU_BANKS; k++) begin : g_en
    logic [GRP_BITS+1:0] w_idx;
    logic                w_in_vl;
    logic                w_on;

    assign w_idx   = {i_row, 2'(k)};
    assign w_in_vl = VL_BITS'(w_idx) < i_vl;
    assign w_on    = i_vm || i_mask[w_idx];
    assign o_en[k] = w_in_vl && w_on;
  end

endmodule

// File: rtl/v_lsu_seq.sv
// Unit-stride vector load/store sequencer between the VRF and the
// 4-bank datamem. Ports: req_* handshake, done/err pulses, dm_* bank
// port (1-cycle read latency), vrf_rd_* store read, vrf_wr_* load write.
module v_lsu_seq
  import v_lsu_seq_pkg::*;
#(
  parameter int VLMAX     = LSU_VLMAX,
  parameter int ADDR_BITS = LSU_ADDR_BITS,
  parameter int GRP_BITS  = $clog2(VLMAX / 4)
) (
  input  logic                   core_clk,
  input  logic                   nrst,

  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_store,
  input  logic [ADDR_BITS-1:0]   req_base,
  input  logic [$clog2(VLMAX):0] req_vl,
  input  logic                   req_vm,
  input  logic [VLMAX-1:0]       req_mask,
  output logic                   done,
  output logic                   err,

  output logic [ADDR_BITS-1:0]   dm_addr,
  output logic [3:0]             dm_write_0,
  output logic [3:0]             dm_write_1,
  output logic [3:0]             dm_write_2,
  output logic [3:0]             dm_write_3,
  output logic [31:0]            dm_wdata_0,
  output logic [31:0]            dm_wdata_1,
  output logic [31:0]            dm_wdata_2,
  output logic [31:0]            dm_wdata_3,
  input  logic [31:0]            dm_rdata_0,
  input  logic [31:0]            dm_rdata_1,
  input  logic [31:0]            dm_rdata_2,
  input  logic [31:0]            dm_rdata_3,

  output logic [GRP_BITS-1:0]    vrf_rd_grp,
  input  logic [127:0]           vrf_rd_data,
  output logic                   vrf_wr_en,
  output logic [GRP_BITS-1:0]    vrf_wr_grp,
  output logic [127:0]           vrf_wr_data,
  output logic [3:0]             vrf_wr_be
);

  localparam int VL_BITS = $clog2(VLMAX) + 1;
  localparam int RW_BITS = VL_BITS - 1;
  localparam int AE_BITS = ADDR_BITS + 1;

  lsu_state_t            r_state;
  logic                  r_store;
  logic                  r_vm;
  logic [VL_BITS-1:0]    r_vl;
  logic [VLMAX-1:0]      r_mask;
  logic [ADDR_BITS-1:0]  r_base;
  logic [GRP_BITS-1:0]   r_row;
  logic [GRP_BITS-1:0]   r_last;
  logic                  r_err;

  // Load return pipe: one stage, matching the datamem read latency.
  logic                  r_pv;
  logic [GRP_BITS-1:0]   r_pgrp;
  logic [3:0]            r_pbe;

  logic                  w_acc;
  logic [VL_BITS:0]      w_vl3;
  logic [RW_BITS-1:0]    w_rows;
  logic [AE_BITS-1:0]    w_end;
  logic                  w_bad_vl;
  logic                  w_bad_st;
  logic                  w_bad_rng;
  logic                  w_err;
  logic                  w_iss;
  logic                  w_st;
  logic [3:0]            w_en;

  // Request checks, evaluated on the raw request.
  assign w_acc    = req_valid && req_ready;
  assign w_vl3    = {1'b0, req_vl} + (VL_BITS + 1)'(3);
  assign w_rows   = w_vl3[VL_BITS:2];
  assign w_end    = {1'b0, req_base}
                  + AE_BITS'(w_rows)
                  - AE_BITS'(1);
  assign w_bad_vl = req_vl > VL_BITS'(VLMAX);
  assign w_bad_st = req_store && req_base[ADDR_BITS-1];

  // Last row must stay inside the address space and inside the
  // region selected by the base MSB. vl=0 touches no row.
  assign w_bad_rng = (req_vl != '0)
                  && (w_end[ADDR_BITS]
                   || (w_end[ADDR_BITS-1]
                       != req_base[ADDR_BITS-1]));
  assign w_err    = w_bad_vl || w_bad_st || w_bad_rng;

  v_lsu_mask_gen #(
    .VLMAX    (VLMAX),
    .GRP_BITS (GRP_BITS),
    .VL_BITS  (VL_BITS)
  ) u_mask (
    .i_vl   (r_vl),
    .i_vm   (r_vm),
    .i_mask (r_mask),
    .i_row  (r_row),
    .o_en   (w_en)
  );

  always_ff @(posedge core_clk) begin
    if (!nrst) begin
      r_state <= LSU_IDLE;
      r_store <= 1'b0;
      r_vm    <= 1'b0;
      r_vl    <= '0;
      r_mask  <= '0;
      r_base  <= '0;
      r_row   <= '0;
      r_last  <= '0;
      r_err   <= 1'b0;
      r_pv    <= 1'b0;
      r_pgrp  <= '0;
      r_pbe   <= '0;
    end else begin
      r_err  <= 1'b0;
      r_pv   <= 1'b0;
      r_pgrp <= '0;
      r_pbe  <= '0;
      unique case (r_state)
        LSU_IDLE: begin
          if (w_acc) begin
            if (w_err) begin
              r_err <= 1'b1;
            end else begin
              r_store <= req_store;
              r_vm    <= req_vm;
              r_vl    <= req_vl;
              r_mask  <= req_mask;
              r_base  <= req_base;
              r_row   <= '0;
              r_last  <= GRP_BITS'(
                w_rows - RW_BITS'(1));
              if (req_vl == '0)
                r_state <= LSU_DRAIN;
              else
                r_state <= LSU_ISSUE;
            end
          end
        end
        LSU_ISSUE: begin
          if (!r_store) begin
            r_pv   <= 1'b1;
            r_pgrp <= r_row;
            r_pbe  <= w_en;
          end
          if (r_row == r_last)
            r_state <= LSU_DRAIN;
          else
            r_row <= r_row + GRP_BITS'(1);
        end
        LSU_DRAIN: begin
          r_state <= LSU_IDLE;
        end
        default: begin
          r_state <= LSU_IDLE;
        end
      endcase
    end
  end

  // Handshake and pulses. Gating with nrst makes an asserted reset
  // cancel any pending completion or VRF write at once.
  assign req_ready = nrst && (r_state == LSU_IDLE);
  assign done      = nrst && (r_state == LSU_DRAIN);
  assign err       = r_err;

  // Issue side.
  assign w_iss = r_state == LSU_ISSUE;
  assign w_st  = w_iss && r_store;

  assign dm_addr    = w_iss
                    ? r_base + ADDR_BITS'(r_row)
                    : '0;
  assign vrf_rd_grp = w_iss ? r_row : '0;

  assign dm_write_0 = {4{w_st && nrst && w_en[0]}};
  assign dm_write_1 = {4{w_st && nrst && w_en[1]}};
  assign dm_write_2 = {4{w_st && nrst && w_en[2]}};
  assign dm_write_3 = {4{w_st && nrst && w_en[3]}};

  assign dm_wdata_0 = w_st ? vrf_rd_data[31:0]   : '0;
  assign dm_wdata_1 = w_st ? vrf_rd_data[63:32]  : '0;
  assign dm_wdata_2 = w_st ? vrf_rd_data[95:64]  : '0;
  assign dm_wdata_3 = w_st ? vrf_rd_data[127:96] : '0;

  // Load return: bank data arrives the cycle after its row issued.
  assign vrf_wr_en   = r_pv && nrst;
  assign vrf_wr_grp  = r_pv ? r_pgrp : '0;
  assign vrf_wr_be   = r_pv ? r_pbe : '0;
  assign vrf_wr_data = r_pv
                     ? {dm_rdata_3, dm_rdata_2,
                        dm_rdata_1, dm_rdata_0}
                     : '0;

endmodule

// File: tb/tb_v_lsu_seq.sv
// Scoreboard bench for v_lsu_seq with a 4-bank datamem model and a
// small VRF image feeding store data.
module tb_v_lsu_seq;

  logic         core_clk = 1'b0;
  logic         nrst;
  logic         req_valid;
  logic         req_ready;
  logic         req_store;
  logic [13:0]  req_base;
  logic [5:0]   req_vl;
  logic         req_vm;
  logic [31:0]  req_mask;
  logic         done;
  logic         err;
  logic [13:0]  dm_addr;
  logic [3:0]   dm_write_0, dm_write_1;
  logic [3:0]   dm_write_2, dm_write_3;
  logic [31:0]  dm_wdata_0, dm_wdata_1;
  logic [31:0]  dm_wdata_2, dm_wdata_3;
  logic [31:0]  dm_rdata_0, dm_rdata_1;
  logic [31:0]  dm_rdata_2, dm_rdata_3;
  logic [2:0]   vrf_rd_grp;
  logic [127:0] vrf_rd_data;
  logic         vrf_wr_en;
  logic [2:0]   vrf_wr_grp;
  logic [127:0] vrf_wr_data;
  logic [3:0]   vrf_wr_be;

  always #5 core_clk = ~core_clk;

  v_lsu_seq dut (
    .core_clk    (core_clk),
    .nrst        (nrst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_base    (req_base),
    .req_vl      (req_vl),
    .req_vm      (req_vm),
    .req_mask    (req_mask),
    .done        (done),
    .err         (err),
    .dm_addr     (dm_addr),
    .dm_write_0  (dm_write_0),
    .dm_write_1  (dm_write_1),
    .dm_write_2  (dm_write_2),
    .dm_write_3  (dm_write_3),
    .dm_wdata_0  (dm_wdata_0),
    .dm_wdata_1  (dm_wdata_1),
    .dm_wdata_2  (dm_wdata_2),
    .dm_wdata_3  (dm_wdata_3),
    .dm_rdata_0  (dm_rdata_0),
    .dm_rdata_1  (dm_rdata_1),
    .dm_rdata_2  (dm_rdata_2),
    .dm_rdata_3  (dm_rdata_3),
    .vrf_rd_grp  (vrf_rd_grp),
    .vrf_rd_data (vrf_rd_data),
    .vrf_wr_en   (vrf_wr_en),
    .vrf_wr_grp  (vrf_wr_grp),
    .vrf_wr_data (vrf_wr_data),
    .vrf_wr_be   (vrf_wr_be)
  );

  // ---------------- memory / VRF models ----------------
  logic [31:0]  mem [4][16384];
  logic [31:0]  rd [4];
  logic [31:0]  wd [4];
  logic [3:0]   we [4];
  logic [127:0] vrf_img [8];

  assign wd[0] = dm_wdata_0;
  assign wd[1] = dm_wdata_1;
  assign wd[2] = dm_wdata_2;
  assign wd[3] = dm_wdata_3;
  assign we[0] = dm_write_0;
  assign we[1] = dm_write_1;
  assign we[2] = dm_write_2;
  assign we[3] = dm_write_3;
  assign dm_rdata_0 = rd[0];
  assign dm_rdata_1 = rd[1];
  assign dm_rdata_2 = rd[2];
  assign dm_rdata_3 = rd[3];
  assign vrf_rd_data = vrf_img[vrf_rd_grp];

  function automatic logic [31:0] pat(int b, logic [13:0] row);
    return {8'h5A, 2'b00, row, 4'h0, 4'(b)};
  endfunction

  function automatic logic [31:0] prot(logic [13:0] row);
    return {8'hC3, 2'b00, row, 8'h00};
  endfunction

  always @(posedge core_clk) begin
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++)
        if (we[b][j])
          mem[b][dm_addr][8*j +: 8] <= wd[b][8*j +: 8];
      rd[b] <= dm_addr[13] ? prot(dm_addr) : mem[b][dm_addr];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int           cyc;
    logic [2:0]   grp;
    logic [127:0] data;
    logic [3:0]   be;
  } vexp_t;

  typedef struct {
    int           cyc;
    logic [13:0]  addr;
    logic [15:0]  we;
    logic [127:0] wd;
  } dexp_t;

  vexp_t qv[$];
  dexp_t qd[$];
  int    qdone[$];
  int    qerr[$];

  int nchk = 0;
  int nbad = 0;
  int cyc = 0;
  int act_cnt = 0;

  always @(posedge core_clk) cyc <= cyc + 1;

  function automatic void chk(string nm,
                              logic [159:0] act,
                              logic [159:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [127:0] rowdata(logic [13:0] a);
    if (a[13])
      return {4{prot(a)}};
    return {pat(3, a), pat(2, a), pat(1, a), pat(0, a)};
  endfunction

  function automatic logic [3:0] exp_be(int vl, logic vm,
                                        logic [31:0] m, int r);
    logic [3:0] be;
    be = '0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = 4 * r + k;
      be[k] = (idx < vl) && (vm || m[idx]);
    end
    return be;
  endfunction

  function automatic void push_load(int c0, logic [13:0] base,
                                    int vl, logic vm,
                                    logic [31:0] m);
    int rows;
    vexp_t e;
    rows = (vl + 3) / 4;
    for (int r = 0; r < rows; r++) begin
      e.cyc  = c0 + 2 + r;
      e.grp  = 3'(r);
      e.data = rowdata(base + 14'(r));
      e.be   = exp_be(vl, vm, m, r);
      qv.push_back(e);
    end
    qdone.push_back(c0 + rows + 1);
  endfunction

  function automatic void push_store(int c0, logic [13:0] base,
                                     int vl, logic vm,
                                     logic [31:0] m);
    int rows;
    dexp_t e;
    logic [3:0] be;
    rows = (vl + 3) / 4;
    for (int r = 0; r < rows; r++) begin
      be = exp_be(vl, vm, m, r);
      e.cyc  = c0 + 1 + r;
      e.addr = base + 14'(r);
      e.we   = {{4{be[3]}}, {4{be[2]}},
                {4{be[1]}}, {4{be[0]}}};
      e.wd   = vrf_img[r];
      if (e.we != '0) qd.push_back(e);
    end
    qdone.push_back(c0 + rows + 1);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT shows an event.
  always @(negedge core_clk) begin
    vexp_t ve;
    dexp_t de;
    int    ec;
    if (dm_addr != '0 || vrf_wr_en ||
        {we[3], we[2], we[1], we[0]} != '0)
      act_cnt++;
    if (vrf_wr_en) begin
      if (qv.size() == 0) begin
        chk("vrf_unexpected", 1, 0);
      end else begin
        ve = qv.pop_front();
        chk("vrf_cyc", 160'(cyc), 160'(ve.cyc));
        chk("vrf_grp", 160'(vrf_wr_grp), 160'(ve.grp));
        chk("vrf_data", 160'(vrf_wr_data), 160'(ve.data));
        chk("vrf_be", 160'(vrf_wr_be), 160'(ve.be));
      end
    end
    if ({we[3], we[2], we[1], we[0]} != '0) begin
      if (qd.size() == 0) begin
        chk("dm_unexpected", 1, 0);
      end else begin
        de = qd.pop_front();
        chk("dm_cyc", 160'(cyc), 160'(de.cyc));
        chk("dm_addr", 160'(dm_addr), 160'(de.addr));
        chk("dm_we", 160'({we[3], we[2], we[1], we[0]}),
            160'(de.we));
        chk("dm_wdata",
            160'({wd[3], wd[2], wd[1], wd[0]}),
            160'(de.wd));
      end
    end
    if (done) begin
      if (qdone.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        ec = qdone.pop_front();
        chk("done_cyc", 160'(cyc), 160'(ec));
      end
    end
    if (err) begin
      if (qerr.size() == 0) begin
        chk("err_unexpected", 1, 0);
      end else begin
        ec = qerr.pop_front();
        chk("err_cyc", 160'(cyc), 160'(ec));
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after the edge
  // that accepted the request, with c0 = the handshake cycle.
  task automatic issue(input logic st, input logic [13:0] base,
                       input logic [5:0] vl, input logic vm,
                       input logic [31:0] m, output int c0);
    req_valid = 1'b1;
    req_store = st;
    req_base  = base;
    req_vl    = vl;
    req_vm    = vm;
    req_mask  = m;
    c0 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge core_clk);
      if (req_ready) begin
        c0 = cyc;
        break;
      end
    end
    if (c0 < 0) chk("accept_timeout", 0, 1);
    @(posedge core_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge core_clk);
      if (req_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("idle_timeout", 0, 1);
    @(posedge core_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, a0;
    vexp_t ve;

    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 16384; r++)
        mem[b][r] = pat(b, 14'(r));
    for (int g = 0; g < 8; g++)
      for (int k = 0; k < 4; k++)
        vrf_img[g][32*k +: 32] = 32'hD000_0000 | (g << 8) | k;

    nrst = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_base = '0;
    req_vl = '0;
    req_vm = 1'b1;
    req_mask = '0;

    // Reset state
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    chk("rst_ready", 160'(req_ready), 0);
    chk("rst_done", 160'(done), 0);
    chk("rst_err", 160'(err), 0);
    chk("rst_vrf_wr_en", 160'(vrf_wr_en), 0);
    chk("rst_dm_addr", 160'(dm_addr), 0);
    @(posedge core_clk);
    #1;
    nrst = 1'b1;
    @(negedge core_clk);
    chk("ready_after_rst", 160'(req_ready), 1);
    @(posedge core_clk);
    #1;

    // Plain load, two rows
    issue(1'b0, 14'h010, 6'd8, 1'b1, '0, c0);
    if (c0 >= 0) push_load(c0, 14'h010, 8, 1'b1, '0);

    // Store, vl=6: second row writes banks 0,1 only
    issue(1'b1, 14'h020, 6'd6, 1'b1, '0, c0);
    if (c0 >= 0) push_store(c0, 14'h020, 6, 1'b1, '0);

    // Readback: banks 2,3 of row 0x021 keep preload
    issue(1'b0, 14'h020, 6'd8, 1'b1, '0, c0);
    if (c0 >= 0) begin
      ve.cyc = c0 + 2;
      ve.grp = 3'd0;
      ve.data = vrf_img[0];
      ve.be = 4'hF;
      qv.push_back(ve);
      ve.cyc = c0 + 3;
      ve.grp = 3'd1;
      ve.data = {pat(3, 14'h021), pat(2, 14'h021),
                 vrf_img[1][63:0]};
      ve.be = 4'hF;
      qv.push_back(ve);
      qdone.push_back(c0 + 3);
    end

    // Masked load, mask 0101
    issue(1'b0, 14'h050, 6'd4, 1'b0, 32'h5, c0);
    if (c0 >= 0) push_load(c0, 14'h050, 4, 1'b0, 32'h5);

    // Rejections and vl=0: no memory or VRF activity
    wait_idle();
    a0 = act_cnt;
    issue(1'b0, 14'h000, 6'd33, 1'b1, '0, c0);
    if (c0 >= 0) qerr.push_back(c0 + 1);
    issue(1'b1, 14'h2000, 6'd4, 1'b1, '0, c0);
    if (c0 >= 0) qerr.push_back(c0 + 1);
    issue(1'b0, 14'h1FFF, 6'd8, 1'b1, '0, c0);
    if (c0 >= 0) qerr.push_back(c0 + 1);
    issue(1'b0, 14'h010, 6'd0, 1'b1, '0, c0);
    if (c0 >= 0) qdone.push_back(c0 + 1);
    repeat (3) @(posedge core_clk);
    #1;
    chk("no_access", 160'(act_cnt), 160'(a0));

    // Protocol-region load
    issue(1'b0, 14'h2004, 6'd4, 1'b1, '0, c0);
    if (c0 >= 0) push_load(c0, 14'h2004, 4, 1'b1, '0);

    // Full-length load, vl=VLMAX
    issue(1'b0, 14'h100, 6'd32, 1'b1, '0, c0);
    if (c0 >= 0) push_load(c0, 14'h100, 32, 1'b1, '0);

    // Reset during ISSUE of a 4-row load: nothing may follow
    issue(1'b0, 14'h030, 6'd16, 1'b1, '0, c0);
    nrst = 1'b0;
    @(negedge core_clk);
    chk("midrst_ready", 160'(req_ready), 0);
    repeat (2) @(posedge core_clk);
    #1;
    nrst = 1'b1;
    @(negedge core_clk);
    chk("midrst_ready_rel", 160'(req_ready), 1);
    @(posedge core_clk);
    #1;

    // Back-to-back: second request waits for the cycle after done
    issue(1'b0, 14'h010, 6'd8, 1'b1, '0, c0);
    if (c0 >= 0) push_load(c0, 14'h010, 8, 1'b1, '0);
    issue(1'b0, 14'h040, 6'd5, 1'b1, '0, c1);
    if (c1 >= 0) push_load(c1, 14'h040, 5, 1'b1, '0);
    chk("b2b_accept_cyc", 160'(c1), 160'(c0 + 4));

    repeat (12) @(posedge core_clk);
    #1;
    chk("left_vrf", 160'(qv.size()), 0);
    chk("left_dm", 160'(qd.size()), 0);
    chk("left_done", 160'(qdone.size()), 0);
    chk("left_err", 160'(qerr.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nbad);
    $finish;
  end

endmodule
